// File: rtl/pio_tx_pkg.sv
// Shared definitions for the PIO completion transmit engine.
// Holds the engine FSM state encoding, the TLP fmt/type codes for the two
// completion flavours, and the header field widths used by the engine and
// its byte-count decoder.
package pio_tx_pkg;

    // Completion engine states: wait for request, memory read, two TX beats
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } pio_tx_state_e;

    // fmt/type codes: 3DW completion with data vs. without
    localparam logic [6:0] FMT_TYPE_CPL  = 7'h0A;
    localparam logic [6:0] FMT_TYPE_CPLD = 7'h4A;

    // Header field widths
    localparam int TC_W    = 3;
    localparam int ATTR_W  = 2;
    localparam int LEN_W   = 10;
    localparam int RID_W   = 16;
    localparam int TAG_W   = 8;
    localparam int BE_W    = 4;
    localparam int ADDR_W  = 11;
    localparam int BC_W    = 12;
    localparam int LADDR_W = 7;
    localparam int DWA_W   = 9;

endpackage

// File: rtl/pio_cpl_bytecount.sv
// Completion byte-count / lower-address decoder (purely combinational).
// Ports:
//   be_i        - first-DW byte enables of the request
//   addrDw_i    - request byte address bits [6:2]
//   byteCount_o - byte count field for completion DW1
//   lowerAddr_o - lower address field for completion DW2
module pio_cpl_bytecount
    import pio_tx_pkg::*;
(
    input  logic [BE_W-1:0]    be_i,
    input  logic [4:0]         addrDw_i,
    output logic [BC_W-1:0]    byteCount_o,
    output logic [LADDR_W-1:0] lowerAddr_o
);

    // Byte count spans from the lowest to the highest enabled byte; an
    // all-zero enable still reports one byte (zero-length read).
    always_comb begin
        byteCount_o = 12'd1;
        casez (be_i)
            4'b1??1: byteCount_o = 12'd4;
            4'b01?1: byteCount_o = 12'd3;
            4'b1?10: byteCount_o = 12'd3;
            4'b0011: byteCount_o = 12'd2;
            4'b0110: byteCount_o = 12'd2;
            4'b1100: byteCount_o = 12'd2;
            default: byteCount_o = 12'd1;
        endcase
    end

    // The two low address bits come from the first enabled byte lane
    always_comb begin
        lowerAddr_o = {addrDw_i, 2'b00};
        casez (be_i)
            4'b???1: lowerAddr_o = {addrDw_i, 2'b00};
            4'b??10: lowerAddr_o = {addrDw_i, 2'b01};
            4'b?100: lowerAddr_o = {addrDw_i, 2'b10};
            4'b1000: lowerAddr_o = {addrDw_i, 2'b11};
            default: lowerAddr_o = {addrDw_i, 2'b00};
        endcase
    end

endmodule

// File: rtl/pio_tx_cpl_engine.sv
// PIO completion transmit engine.
// Latches a completion request from the RX stage, reads one DW from PIO
// memory, and emits a 3DW Cpl/CplD TLP as two 64-bit stream beats.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_*             - completion request fields, sampled when req_compl=1
//   completer_id      - bus/dev/fn placed in the completion header
//   rd_addr, rd_be    - PIO memory read address (DW) and byte enables
//   rd_data           - PIO memory read data, one-cycle latency
//   tx_t*             - TX stream (DW0 in tdata[31:0])
//   compl_done        - one-cycle pulse after the last beat is accepted
//   req_overrun       - sticky flag for requests arriving while busy
// Configuration: define PIO_TX_OVERRUN_DET_EN to enable overrun detection;
// otherwise req_overrun is tied low.
module pio_tx_cpl_engine
    import pio_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_compl,
    input  logic               req_compl_wd,
    input  logic [TC_W-1:0]    req_tc,
    input  logic [ATTR_W-1:0]  req_attr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [RID_W-1:0]   req_rid,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [BE_W-1:0]    req_be,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [15:0]        completer_id,
    output logic [DWA_W-1:0]   rd_addr,
    output logic [BE_W-1:0]    rd_be,
    input  logic [31:0]        rd_data,
    output logic [63:0]        tx_tdata,
    output logic [7:0]         tx_tkeep,
    output logic               tx_tlast,
    output logic               tx_tvalid,
    input  logic               tx_tready,
    output logic               compl_done,
    output logic               req_overrun
);

    pio_tx_state_e state_q, state_d;

    logic                reqWd_q;
    logic [TC_W-1:0]     reqTc_q;
    logic [ATTR_W-1:0]   reqAttr_q;
    logic [LEN_W-1:0]    reqLen_q;
    logic [RID_W-1:0]    reqRid_q;
    logic [TAG_W-1:0]    reqTag_q;
    logic [BE_W-1:0]     reqBe_q;
    logic [ADDR_W-1:2]   reqAddr_q;
    logic [31:0]         data_q;
    logic                dataPend_q;
    logic                complDone_q;

    logic [BC_W-1:0]     byteCount;
    logic [LADDR_W-1:0]  lowerAddr;
    logic [31:0]         dw0, dw1, dw2;
    logic                unusedAddrLsbs;

    // The two byte-offset address bits are carried by the byte enables
    assign unusedAddrLsbs = ^req_addr[1:0];

    pio_cpl_bytecount u_bytecount (
        .be_i        (reqBe_q),
        .addrDw_i    (reqAddr_q[6:2]),
        .byteCount_o (byteCount),
        .lowerAddr_o (lowerAddr)
    );

    // Completion header words built from the latched request
    assign dw0 = {1'b0, (reqWd_q ? FMT_TYPE_CPLD : FMT_TYPE_CPL), 1'b0, reqTc_q,
                  4'h0, 1'b0, 1'b0, reqAttr_q, 2'b00, reqLen_q};
    assign dw1 = {completer_id, 3'b000, 1'b0, byteCount};
    assign dw2 = {reqRid_q, reqTag_q, 1'b0, lowerAddr};

    // State, request latch and data capture. dataPend_q marks the first
    // BEAT0 cycle so the memory word is captured once and then held stable
    // under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dataPend_q  <= 1'b0;
            complDone_q <= 1'b0;
            reqWd_q     <= 1'b0;
            reqTc_q     <= '0;
            reqAttr_q   <= '0;
            reqLen_q    <= '0;
            reqRid_q    <= '0;
            reqTag_q    <= '0;
            reqBe_q     <= '0;
            reqAddr_q   <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            dataPend_q  <= (state_q == RD);
            complDone_q <= (state_q == BEAT1) && tx_tready;
            if (state_q == IDLE && req_compl) begin
                reqWd_q   <= req_compl_wd;
                reqTc_q   <= req_tc;
                reqAttr_q <= req_attr;
                reqLen_q  <= req_len;
                reqRid_q  <= req_rid;
                reqTag_q  <= req_tag;
                reqBe_q   <= req_be;
                reqAddr_q <= req_addr[ADDR_W-1:2];
            end
            if (state_q == BEAT0 && dataPend_q) begin
                data_q <= rd_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_compl) state_d = RD;
            RD:      state_d = BEAT0;
            BEAT0:   if (tx_tready) state_d = BEAT1;
            BEAT1:   if (tx_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state and latched registers only, so they stay
    // stable while the sink stalls; reset forces them low immediately.
    always_comb begin
        rd_addr   = '0;
        rd_be     = '0;
        tx_tdata  = '0;
        tx_tkeep  = '0;
        tx_tlast  = 1'b0;
        tx_tvalid = 1'b0;
        if (!rst && state_q != IDLE) begin
            rd_addr = reqAddr_q;
            rd_be   = reqBe_q;
            case (state_q)
                BEAT0: begin
                    tx_tvalid = 1'b1;
                    tx_tdata  = {dw1, dw0};
                    tx_tkeep  = 8'hFF;
                end
                BEAT1: begin
                    tx_tvalid = 1'b1;
                    tx_tlast  = 1'b1;
                    if (reqWd_q) begin
                        tx_tdata = {data_q, dw2};
                        tx_tkeep = 8'hFF;
                    end else begin
                        tx_tdata = {32'h0, dw2};
                        tx_tkeep = 8'h0F;
                    end
                end
                default: ;
            endcase
        end
    end

    assign compl_done = complDone_q && !rst;

`ifdef PIO_TX_OVERRUN_DET_EN
    logic overrun_q;

    // Any request seen while busy is dropped; remember it until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (req_compl && state_q != IDLE) begin
            overrun_q <= 1'b1;
        end
    end

    assign req_overrun = overrun_q && !rst;
`else
    assign req_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pio_tx_cpl_engine.sv
// Directed testbench for pio_tx_cpl_engine.
// Covers reset state, CplD and Cpl formatting, byte-enable decode,
// backpressure hold, back-to-back requests, overrun handling and reset
// mid-packet. Honours PIO_TX_OVERRUN_DET_EN for the expected overrun flag.
module tb_pio_tx_cpl_engine;

    logic        clk;
    logic        rst;
    logic        req_compl;
    logic        req_compl_wd;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [3:0]  req_be;
    logic [10:0] req_addr;
    logic [15:0] completer_id;
    logic [8:0]  rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        compl_done;
    logic        req_overrun;

    logic [31:0] memWord;
    logic        overrunExp;
    int          passCount;
    int          failCount;
    int          totalCount;

    pio_tx_cpl_engine dut (
        .clk          (clk),
        .rst          (rst),
        .req_compl    (req_compl),
        .req_compl_wd (req_compl_wd),
        .req_tc       (req_tc),
        .req_attr     (req_attr),
        .req_len      (req_len),
        .req_rid      (req_rid),
        .req_tag      (req_tag),
        .req_be       (req_be),
        .req_addr     (req_addr),
        .completer_id (completer_id),
        .rd_addr      (rd_addr),
        .rd_be        (rd_be),
        .rd_data      (rd_data),
        .tx_tdata     (tx_tdata),
        .tx_tkeep     (tx_tkeep),
        .tx_tlast     (tx_tlast),
        .tx_tvalid    (tx_tvalid),
        .tx_tready    (tx_tready),
        .compl_done   (compl_done),
        .req_overrun  (req_overrun)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO memory stand-in: one-cycle read latency
    always @(posedge clk) rd_data <= memWord;

    // Advance one cycle, sample point 1 ns after the edge; request is a pulse
    task automatic stepCycle();
        @(posedge clk);
        #1;
        req_compl = 1'b0;
    endtask

    task automatic applyStimulus(input logic wd, input logic [2:0] tc,
                                 input logic [1:0] attr, input logic [9:0] len,
                                 input logic [15:0] rid, input logic [7:0] tag,
                                 input logic [3:0] be, input logic [10:0] addr);
        req_compl_wd = wd;
        req_tc       = tc;
        req_attr     = attr;
        req_len      = len;
        req_rid      = rid;
        req_tag      = tag;
        req_be       = be;
        req_addr     = addr;
        req_compl    = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        passCount    = 0;
        failCount    = 0;
        totalCount   = 0;
        rst          = 1'b1;
        req_compl    = 1'b0;
        req_compl_wd = 1'b0;
        req_tc       = '0;
        req_attr     = '0;
        req_len      = '0;
        req_rid      = '0;
        req_tag      = '0;
        req_be       = '0;
        req_addr     = '0;
        completer_id = 16'hABCD;
        tx_tready    = 1'b1;
        memWord      = 32'h0;
`ifdef PIO_TX_OVERRUN_DET_EN
        overrunExp   = 1'b1;
`else
        overrunExp   = 1'b0;
`endif

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("rst_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("rst_tdata", tx_tdata, 64'h0);
        checkOutput("rst_compl_done", {63'h0, compl_done}, 64'h0);
        checkOutput("rst_rd_addr", {55'h0, rd_addr}, 64'h0);
        rst = 1'b0;
        stepCycle();
        checkOutput("idle_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("idle_rd_be", {60'h0, rd_be}, 64'h0);
        checkOutput("idle_overrun", {63'h0, req_overrun}, 64'h0);

        $display("[TB] CplD with full byte enables");
        memWord = 32'hDEADBEEF;
        applyStimulus(1'b1, 3'd0, 2'd0, 10'd1, 16'h1234, 8'h5A, 4'hF, 11'h010);
        stepCycle();
        checkOutput("t1_rd_addr", {55'h0, rd_addr}, 64'h004);
        checkOutput("t1_rd_be", {60'h0, rd_be}, 64'hF);
        checkOutput("t1_rd_tvalid", {63'h0, tx_tvalid}, 64'h0);
        stepCycle();
        checkOutput("t1_b0_tvalid", {63'h0, tx_tvalid}, 64'h1);
        checkOutput("t1_b0_tdata", tx_tdata, 64'hABCD0004_4A000001);
        checkOutput("t1_b0_tkeep", {56'h0, tx_tkeep}, 64'hFF);
        checkOutput("t1_b0_tlast", {63'h0, tx_tlast}, 64'h0);
        stepCycle();
        checkOutput("t1_b1_tdata", tx_tdata, 64'hDEADBEEF_12345A10);
        checkOutput("t1_b1_tkeep", {56'h0, tx_tkeep}, 64'hFF);
        checkOutput("t1_b1_tlast", {63'h0, tx_tlast}, 64'h1);
        checkOutput("t1_b1_compl_done", {63'h0, compl_done}, 64'h0);
        stepCycle();
        checkOutput("t1_compl_done", {63'h0, compl_done}, 64'h1);
        checkOutput("t1_done_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("t1_done_rd_addr", {55'h0, rd_addr}, 64'h0);
        stepCycle();
        checkOutput("t1_compl_done_pulse", {63'h0, compl_done}, 64'h0);

        $display("[TB] Cpl without data, BE 0110 at addr 0x007");
        applyStimulus(1'b0, 3'd5, 2'd2, 10'd0, 16'h0BEE, 8'h11, 4'b0110, 11'h007);
        stepCycle();
        checkOutput("t2_rd_addr", {55'h0, rd_addr}, 64'h001);
        checkOutput("t2_rd_be", {60'h0, rd_be}, 64'h6);
        stepCycle();
        checkOutput("t2_b0_tdata", tx_tdata, 64'hABCD0002_0A502000);
        stepCycle();
        checkOutput("t2_b1_tdata", tx_tdata, 64'h00000000_0BEE1105);
        checkOutput("t2_b1_tkeep", {56'h0, tx_tkeep}, 64'h0F);
        checkOutput("t2_b1_tlast", {63'h0, tx_tlast}, 64'h1);
        stepCycle();
        checkOutput("t2_compl_done", {63'h0, compl_done}, 64'h1);

        $display("[TB] Request in compl_done cycle, BE 0000, 5-cycle stall");
        memWord   = 32'hCAFEF00D;
        tx_tready = 1'b0;
        applyStimulus(1'b1, 3'd7, 2'd3, 10'h3FF, 16'hFFFF, 8'hFF, 4'b0000, 11'h7FC);
        stepCycle();
        checkOutput("t3_compl_done_low", {63'h0, compl_done}, 64'h0);
        checkOutput("t3_rd_addr", {55'h0, rd_addr}, 64'h1FF);
        checkOutput("t3_rd_be", {60'h0, rd_be}, 64'h0);
        stepCycle();
        checkOutput("t3_b0_tdata", tx_tdata, 64'hABCD0001_4A7033FF);
        checkOutput("t3_b0_tvalid", {63'h0, tx_tvalid}, 64'h1);
        memWord = 32'h11111111;
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkOutput("t3_stall_tdata", tx_tdata, 64'hABCD0001_4A7033FF);
            checkOutput("t3_stall_tvalid", {63'h0, tx_tvalid}, 64'h1);
            checkOutput("t3_stall_tlast", {63'h0, tx_tlast}, 64'h0);
        end
        stepCycle();
        checkOutput("t3_accept_tdata", tx_tdata, 64'hABCD0001_4A7033FF);
        tx_tready = 1'b1;
        stepCycle();
        checkOutput("t3_b1_tdata", tx_tdata, 64'hCAFEF00D_FFFFFF7C);
        checkOutput("t3_b1_tkeep", {56'h0, tx_tkeep}, 64'hFF);
        checkOutput("t3_b1_compl_done", {63'h0, compl_done}, 64'h0);
        stepCycle();
        checkOutput("t3_compl_done_n9", {63'h0, compl_done}, 64'h1);

        $display("[TB] Overrun: request pulsed during BEAT0");
        tx_tready = 1'b0;
        memWord   = 32'h55AA55AA;
        applyStimulus(1'b1, 3'd0, 2'd0, 10'd1, 16'h0102, 8'h03, 4'b1000, 11'h003);
        stepCycle();
        checkOutput("t4_rd_be", {60'h0, rd_be}, 64'h8);
        stepCycle();
        checkOutput("t4_b0_tdata", tx_tdata, 64'hABCD0001_4A000001);
        applyStimulus(1'b0, 3'd1, 2'd1, 10'd5, 16'hAAAA, 8'hBB, 4'hF, 11'h100);
        stepCycle();
        checkOutput("t4_held_tdata", tx_tdata, 64'hABCD0001_4A000001);
        checkOutput("t4_held_rd_be", {60'h0, rd_be}, 64'h8);
        checkOutput("t4_held_rd_addr", {55'h0, rd_addr}, 64'h000);
        stepCycle();
        checkOutput("t4_overrun", {63'h0, req_overrun}, {63'h0, overrunExp});
        tx_tready = 1'b1;
        stepCycle();
        checkOutput("t4_b1_tdata", tx_tdata, 64'h55AA55AA_01020303);
        stepCycle();
        checkOutput("t4_compl_done", {63'h0, compl_done}, 64'h1);
        stepCycle();
        checkOutput("t4_no_spurious_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("t4_overrun_sticky", {63'h0, req_overrun}, {63'h0, overrunExp});

        $display("[TB] Reset asserted in BEAT1");
        tx_tready = 1'b0;
        applyStimulus(1'b1, 3'd0, 2'd0, 10'd1, 16'h1234, 8'h5A, 4'hF, 11'h010);
        stepCycle();
        stepCycle();
        tx_tready = 1'b1;
        stepCycle();
        checkOutput("t5_b1_tlast", {63'h0, tx_tlast}, 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("t5_rst_tdata", tx_tdata, 64'h0);
        checkOutput("t5_rst_tkeep", {56'h0, tx_tkeep}, 64'h0);
        checkOutput("t5_rst_tlast", {63'h0, tx_tlast}, 64'h0);
        checkOutput("t5_rst_rd_addr", {55'h0, rd_addr}, 64'h0);
        checkOutput("t5_rst_overrun", {63'h0, req_overrun}, 64'h0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("t5_post_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("t5_post_compl_done", {63'h0, compl_done}, 64'h0);
        checkOutput("t5_post_overrun", {63'h0, req_overrun}, 64'h0);
        stepCycle();
        checkOutput("t5_idle_compl_done", {63'h0, compl_done}, 64'h0);
        checkOutput("t5_idle_tvalid", {63'h0, tx_tvalid}, 64'h0);
        checkOutput("t5_idle_rd_be", {60'h0, rd_be}, 64'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
